wb_master_bridge: RTL

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

---
 rtl/wb_master_bridge_if.sv | 37 +++
 rtl/wb_master_bridge.sv | 131 +++++++++++++
 2 files changed

// File: rtl/wb_master_bridge_if.sv
// Host command/response channel plus Wishbone B4 classic master signals for wb_master_bridge.
interface wb_master_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int GRANULE    = 8
);
    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_adr_i;
    logic [DATA_WIDTH-1:0] cmd_dat_i;
    logic [SEL_WIDTH-1:0]  cmd_sel_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_dat_o;
    logic                  rsp_err_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic                  we_o;
    logic                  stb_o;
    logic                  cyc_o;
    logic                  ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i, dat_i, ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i, dat_i, ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Single-transfer Wishbone B4 classic master driven by a valid/ready host command channel.
// Define WB_MASTER_BRIDGE_TIMEOUT_EN to compile in the BUS-phase watchdog (TIMEOUT_CYCLES).
module wb_master_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int GRANULE        = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    wb_master_bridge_if.master bus
);
    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  cmd_ready;

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    // Gated by rst_ni so the host sees "not ready" for the whole reset pulse.
    assign cmd_ready = (state_q == IDLE) && rst_ni;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rsp_dat_d = rsp_dat_q;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
        cnt_d     = cnt_q;
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i && cmd_ready) begin
                    state_d = BUS;
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    sel_d   = bus.cmd_sel_i;
                    we_d    = bus.cmd_we_i;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                if (bus.ack_i) begin
                    state_d   = RESP;
                    rsp_dat_d = we_q ? '0 : bus.dat_i;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                end
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rsp_dat_q <= '0;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.cyc_o       = (state_q == BUS);
    assign bus.stb_o       = (state_q == BUS);
    assign bus.adr_o       = adr_q;
    assign bus.dat_o       = dat_q;
    assign bus.sel_o       = sel_q;
    assign bus.we_o        = we_q;
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_dat_o   = rsp_dat_q;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
    assign bus.rsp_err_o   = rsp_err_q;
`else
    assign bus.rsp_err_o   = 1'b0;
`endif
endmodule
